// File: rtl/mprc_io_req_queue_pkg.sv
// Shared definitions for the uncached/MMIO request queue: command and
// operand-type codes plus the fixed field widths of a request.
package mprc_io_req_queue_pkg;

    localparam int CMD_W = 5;
    localparam int TYP_W = 3;

    // Memory command codes (M_X*)
    localparam logic [CMD_W-1:0] M_XRD    = 5'b00000;
    localparam logic [CMD_W-1:0] M_XWR    = 5'b00001;
    localparam logic [CMD_W-1:0] M_PFR    = 5'b00010;
    localparam logic [CMD_W-1:0] M_PFW    = 5'b00011;
    localparam logic [CMD_W-1:0] M_XA_ADD = 5'b01000;
    localparam logic [CMD_W-1:0] M_XLR    = 5'b00110;
    localparam logic [CMD_W-1:0] M_XSC    = 5'b00111;

    // Operand size/sign codes (MT_*)
    localparam logic [TYP_W-1:0] MT_X  = 3'd0;
    localparam logic [TYP_W-1:0] MT_B  = 3'd1;
    localparam logic [TYP_W-1:0] MT_H  = 3'd2;
    localparam logic [TYP_W-1:0] MT_W  = 3'd3;
    localparam logic [TYP_W-1:0] MT_D  = 3'd4;
    localparam logic [TYP_W-1:0] MT_BU = 3'd5;
    localparam logic [TYP_W-1:0] MT_HU = 3'd6;
    localparam logic [TYP_W-1:0] MT_WU = 3'd7;

    // Width of one packed queue entry {addr, tag, cmd, typ, phys, data}
    function automatic int entry_width(input int addr_w, input int tag_w, input int data_w);
        return addr_w + tag_w + CMD_W + TYP_W + 1 + data_w;
    endfunction

endpackage

// File: rtl/mprc_io_req_queue_ram.sv
// Entry storage for the IO request queue: one synchronous write port
// (tail) and one asynchronous read port (head) so the head entry can be
// presented combinationally. Contents are not reset.
module mprc_io_req_queue_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the offered entry into its slot
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mprc_io_req_queue.sv
// In-order buffer for uncached/MMIO requests between the cache pipeline
// and the IO MSHR. A freshly enqueued entry stays "pending" for one cycle
// so the late pipeline kill can retract it before it is ever presented.
module mprc_io_req_queue
    import mprc_io_req_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 40,
    parameter int TAG_W  = 9,
    parameter int DATA_W = 64,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_enq_valid,
    output logic              io_enq_ready,
    input  logic [ADDR_W-1:0] io_enq_addr,
    input  logic [TAG_W-1:0]  io_enq_tag,
    input  logic [CMD_W-1:0]  io_enq_cmd,
    input  logic [TYP_W-1:0]  io_enq_typ,
    input  logic              io_enq_phys,
    input  logic [DATA_W-1:0] io_enq_data,
    input  logic              io_enq_kill,
    output logic              io_deq_valid,
    input  logic              io_deq_ready,
    output logic [ADDR_W-1:0] io_deq_addr,
    output logic [TAG_W-1:0]  io_deq_tag,
    output logic [CMD_W-1:0]  io_deq_cmd,
    output logic [TYP_W-1:0]  io_deq_typ,
    output logic              io_deq_phys,
    output logic [DATA_W-1:0] io_deq_data,
    output logic              io_deq_kill,
    output logic [CNT_W-1:0]  io_count
);

    localparam int ENTRY_W = entry_width(ADDR_W, TAG_W, DATA_W);

    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pend_q, pend_d;
    logic [IDX_W-1:0] pend_idx_q, pend_idx_d;

    logic             kill_eff;
    logic             enq_fire;
    logic             deq_fire;
    logic [IDX_W-1:0] wr_idx;
    logic [ENTRY_W-1:0] wr_word;
    logic [ENTRY_W-1:0] rd_word;

    // A kill only means something while an entry is pending
    assign kill_eff = io_enq_kill & pend_q;

    // Readiness uses the pre-kill count: a kill never frees a slot for the same cycle
    assign io_enq_ready = (count_q < CNT_W'(DEPTH));
    assign enq_fire     = io_enq_valid & io_enq_ready;

    // The pending entry is always tail-1, so it is the head only when it is the sole entry
    assign io_deq_valid = (count_q != '0) & ~(pend_q & (head_q == pend_idx_q));
    assign deq_fire     = io_deq_valid & io_deq_ready;

    // Rollback applies before the new write, so a kill+enq reuses the killed slot
    assign wr_idx  = kill_eff ? (tail_q - IDX_W'(1)) : tail_q;
    assign wr_word = {io_enq_addr, io_enq_tag, io_enq_cmd, io_enq_typ, io_enq_phys, io_enq_data};

    // Next-state for pointers, occupancy and the kill window
    always_comb begin
        head_d     = deq_fire ? (head_q + IDX_W'(1)) : head_q;
        tail_d     = enq_fire ? (wr_idx + IDX_W'(1)) : wr_idx;
        count_d    = count_q + CNT_W'(enq_fire) - CNT_W'(kill_eff) - CNT_W'(deq_fire);
        pend_d     = enq_fire;
        pend_idx_d = enq_fire ? wr_idx : pend_idx_q;
    end

    // State registers; reset discards every entry including a pending one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
        end
    end

    mprc_io_req_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (enq_fire),
        .waddr_i (wr_idx),
        .wdata_i (wr_word),
        .raddr_i (head_q),
        .rdata_o (rd_word)
    );

    assign {io_deq_addr, io_deq_tag, io_deq_cmd, io_deq_typ, io_deq_phys, io_deq_data} = rd_word;

    // Kills are resolved inside the queue, so nothing killed leaves it
    assign io_deq_kill = 1'b0;
    assign io_count    = count_q;

endmodule
